// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if
//   Sample-in / bin-out stream bundle for the FFT frame controller.
//
//   Handshake: a beat transfers on a rising clk edge where valid and ready
//   are both high. The source holds valid and its payload (data, last)
//   unchanged until that beat happens. The sink may raise or lower ready
//   freely.
//
//   Signals
//     s_valid / s_ready / s_data : input samples, front-end -> controller
//     m_valid / m_ready / m_data / m_last : output bins, controller -> consumer
//
//   Modports
//     master : controller side (accepts samples, produces bins)
//     slave  : environment side (produces samples, accepts bins)
interface fft_frame_ctrl_if #(
    parameter int DW = 32
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frame sequencer and memory arbiter for the 1024-point FFT. Owns the
//   single-port BSRAM bank fft0: fills it with N input samples (LOAD), hands
//   it to fft1024 (RUN), then streams the N result bins out (UNLOAD).
//
//   Optional build macro FFT_BITREV_LOAD_EN: when defined, sample k is
//   written to address bitrev(k) so the engine can skip its input
//   permutation; otherwise sample k goes to address k. Unload order is
//   natural (address 0..N-1) either way.
//
//   Ports
//     clk, rst_n            : clock, asynchronous active-low reset
//     bus (master)          : s_valid/s_ready/s_data in, m_valid/m_ready/m_data/m_last out
//     fft_start             : level to fft1024, high for the whole RUN state
//     fft_finish            : done pulse from fft1024 (only honoured in RUN)
//     fft_ce/oce/wre/ad/din : engine BSRAM controls, passed through in RUN
//     fft_dout              : BSRAM read data to the engine
//     mem_ce/oce/wre/ad/din : BSRAM fft0 controls
//     mem_dout              : BSRAM read data (1-cycle latency)
//     busy                  : high in every state except IDLE
//     dbg_state             : current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 UNLOAD)
module fft_frame_ctrl #(
    parameter int N  = 1024,
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_frame_ctrl_if.master bus,
    output logic            fft_start,
    input  logic            fft_finish,
    input  logic            fft_ce,
    input  logic            fft_oce,
    input  logic            fft_wre,
    input  logic [AW-1:0]   fft_ad,
    input  logic [DW-1:0]   fft_din,
    output logic [DW-1:0]   fft_dout,
    output logic            mem_ce,
    output logic            mem_oce,
    output logic            mem_wre,
    output logic [AW-1:0]   mem_ad,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout,
    output logic            busy,
    output logic [1:0]      dbg_state
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] waddr;
    logic          rd_done;     // all N reads issued for this frame
    logic          rd_pend;     // read issued last cycle, data on mem_dout now
    logic          pend_last;   // the pending read is bin N-1
    logic [1:0]    occ;         // skid buffer occupancy
    logic [DW-1:0] buf_data [2];
    logic          buf_last [2];
    logic          s_beat;
    logic          pop;
    logic          last_pop;
    logic          rd_issue;

    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) r[i] = v[CW-1-i];
        return r;
    endfunction

`ifdef FFT_BITREV_LOAD_EN
    assign waddr = bitrev(wcnt);
`else
    assign waddr = wcnt;
`endif

    assign s_beat   = (state == LOAD) && bus.s_valid;
    assign pop      = (occ != 2'd0) && bus.m_ready;
    assign last_pop = pop && buf_last[0];
    // Occupancy is counted after this cycle's pop so a steady m_ready gives
    // one bin per cycle while the buffer still never exceeds two entries.
    assign rd_issue = (state == UNLOAD) && !rd_done &&
                      (({1'b0, occ} - {2'b00, pop} + {2'b00, rd_pend}) < 3'd2);

    assign bus.s_ready = (state == LOAD);
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = (occ != 2'd0) ? buf_data[0] : '0;
    assign bus.m_last  = (occ != 2'd0) && buf_last[0];
    assign fft_start   = (state == RUN);
    assign fft_dout    = mem_dout;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_ce    = 1'b0;
        mem_oce   = 1'b0;
        mem_wre   = 1'b0;
        mem_ad    = '0;
        mem_din   = '0;
        case (state)
            IDLE: state_nxt = LOAD;
            LOAD: begin
                if (s_beat) begin
                    mem_ce  = 1'b1;
                    mem_wre = 1'b1;
                    mem_ad  = AW'(waddr);
                    mem_din = bus.s_data;
                    if (wcnt == CW'(N-1)) state_nxt = RUN;
                end
            end
            RUN: begin
                mem_ce  = fft_ce;
                mem_oce = fft_oce;
                mem_wre = fft_wre;
                mem_ad  = fft_ad;
                mem_din = fft_din;
                if (fft_finish) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                if (rd_issue) begin
                    mem_ce  = 1'b1;
                    mem_oce = 1'b1;
                    mem_ad  = AW'(rcnt);
                end
                if (last_pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt        <= '0;
            rcnt        <= '0;
            rd_done     <= 1'b0;
            rd_pend     <= 1'b0;
            pend_last   <= 1'b0;
            occ         <= 2'd0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else begin
            if (s_beat) wcnt <= wcnt + CW'(1);
            if (rd_issue) begin
                rcnt <= rcnt + CW'(1);
                if (rcnt == CW'(N-1)) rd_done <= 1'b1;
            end
            if (last_pop) rd_done <= 1'b0;
            rd_pend   <= rd_issue;
            pend_last <= rd_issue && (rcnt == CW'(N-1));

            // Two-entry FIFO, head always in slot 0.
            case ({pop, rd_pend})
                2'b01: begin
                    buf_data[occ[0]] <= mem_dout;
                    buf_last[occ[0]] <= pend_last;
                    occ              <= occ + 2'd1;
                end
                2'b10: begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    occ         <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_data[0] <= mem_dout;
                        buf_last[0] <= pend_last;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_last[0] <= buf_last[1];
                        buf_data[1] <= mem_dout;
                        buf_last[1] <= pend_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
